// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register for the EX-stage ALU. It decodes
//                ALUOp/funct into the 4-bit ALU control code and selects
//                operand B (rs2 data or immediate). It registers all datapath
//                and control fields for EX. It also detects load-use hazards
//                and inserts a bubble for each one. The stage supports a
//                global freeze (ext_stall) and a branch flush (flush).
//
//  Ports       :
//    clk, reset            clock / synchronous active-high reset
//    ext_stall             freeze: every EX register holds its value
//    flush                 kill the instruction entering EX
//    id_*                  decoded fields of the instruction in ID
//    hazard_stall          combinational; PC and IF/ID must hold this cycle
//    ex_*                  registered fields presented to EX
//
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ext_stall,
    input  logic            flush,

    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic [1:0]      id_alu_op,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7b5,
    input  logic            id_alu_src,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_reg_write,
    input  logic            id_mem_to_reg,
    input  logic            id_branch,

    output logic            hazard_stall,

    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_store_data,
    output logic [RA_W-1:0] ex_rs1,
    output logic [RA_W-1:0] ex_rs2,
    output logic [RA_W-1:0] ex_rd,
    output logic [3:0]      ex_alu_ctrl,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_mem_to_reg,
    output logic            ex_branch,
    output logic            ex_illegal
);

    // ALU control encodings
    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;

    // ALUOp encodings
    localparam logic [1:0] c_OP_MEM    = 2'b00;
    localparam logic [1:0] c_OP_BRANCH = 2'b01;
    localparam logic [1:0] c_OP_RTYPE  = 2'b10;
    localparam logic [1:0] c_OP_ITYPE  = 2'b11;

    // funct3 encodings recognised by the decoder
    localparam logic [2:0] c_F3_ADD = 3'b000;
    localparam logic [2:0] c_F3_OR  = 3'b110;
    localparam logic [2:0] c_F3_AND = 3'b111;

    localparam logic [RA_W-1:0] c_X0 = '0;

    // ------------------------------------------------------------------------
    // EX-stage registers
    // ------------------------------------------------------------------------
    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_store_data;
    logic [RA_W-1:0] r_rs1;
    logic [RA_W-1:0] r_rs2;
    logic [RA_W-1:0] r_rd;
    logic [3:0]      r_alu_ctrl;
    logic            r_mem_read;
    logic            r_mem_write;
    logic            r_reg_write;
    logic            r_mem_to_reg;
    logic            r_branch;
    logic            r_illegal;

    // ------------------------------------------------------------------------
    // ALU control decode
    // Unsupported combinations fall back to ADD and raise illegal. The
    // instruction still flows into EX so that the trap logic downstream
    // sees it.
    // ------------------------------------------------------------------------
    logic [3:0] w_alu_ctrl;
    logic       w_illegal;

    always_comb begin
        w_alu_ctrl = c_ALU_ADD;
        w_illegal  = 1'b0;
        case (id_alu_op)
            c_OP_MEM:    w_alu_ctrl = c_ALU_ADD;
            c_OP_BRANCH: w_alu_ctrl = c_ALU_SUB;
            c_OP_RTYPE: begin
                case (id_funct3)
                    c_F3_ADD: w_alu_ctrl = id_funct7b5 ? c_ALU_SUB : c_ALU_ADD;
                    c_F3_AND: w_alu_ctrl = c_ALU_AND;
                    c_F3_OR:  w_alu_ctrl = c_ALU_OR;
                    default:  w_illegal  = 1'b1;
                endcase
            end
            c_OP_ITYPE: begin
                // There is no SUBI, so funct7b5 does not matter for funct3=000.
                case (id_funct3)
                    c_F3_ADD: w_alu_ctrl = c_ALU_ADD;
                    c_F3_AND: w_alu_ctrl = c_ALU_AND;
                    c_F3_OR:  w_alu_ctrl = c_ALU_OR;
                    default:  w_illegal  = 1'b1;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Operand B mux
    logic [XLEN-1:0] w_operand_b;
    assign w_operand_b = id_alu_src ? id_imm : id_rs2_data;

    // ------------------------------------------------------------------------
    // Load-use hazard
    // A load in EX has no data until MEM, so a dependent instruction in ID
    // must wait one cycle. The bubble clears ex_mem_read, and that releases
    // the stall on the next cycle. A flush kills the ID instruction anyway,
    // so the upstream stages need not hold.
    // ------------------------------------------------------------------------
    logic w_rs1_match;
    logic w_rs2_match;
    logic w_raw_hazard;

    assign w_rs1_match  = id_uses_rs1 & (id_rs1 == r_rd);
    assign w_rs2_match  = id_uses_rs2 & (id_rs2 == r_rd);
    assign w_raw_hazard = id_valid & r_valid & r_mem_read & (r_rd != c_X0)
                        & (w_rs1_match | w_rs2_match);
    assign hazard_stall = w_raw_hazard & ~flush;

    logic w_bubble;
    assign w_bubble = flush | hazard_stall | ~id_valid;

    // ------------------------------------------------------------------------
    // Pipeline register
    // Reset and bubble have the same contents. An ext_stall freezes the
    // register even if a flush or hazard is present. The sources keep those
    // requests asserted until the freeze is released.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || (!ext_stall && w_bubble)) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_store_data <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_alu_ctrl   <= c_ALU_ADD;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_branch     <= 1'b0;
            r_illegal    <= 1'b0;
        end else if (!ext_stall) begin
            r_valid      <= 1'b1;
            r_pc         <= id_pc;
            r_a          <= id_rs1_data;
            r_b          <= w_operand_b;
            r_store_data <= id_rs2_data;
            r_rs1        <= id_rs1;
            r_rs2        <= id_rs2;
            r_rd         <= id_rd;
            r_alu_ctrl   <= w_alu_ctrl;
            r_mem_read   <= id_mem_read;
            r_mem_write  <= id_mem_write;
            r_reg_write  <= id_reg_write;
            r_mem_to_reg <= id_mem_to_reg;
            r_branch     <= id_branch;
            r_illegal    <= w_illegal;
        end
    end

    assign ex_valid      = r_valid;
    assign ex_pc         = r_pc;
    assign ex_a          = r_a;
    assign ex_b          = r_b;
    assign ex_store_data = r_store_data;
    assign ex_rs1        = r_rs1;
    assign ex_rs2        = r_rs2;
    assign ex_rd         = r_rd;
    assign ex_alu_ctrl   = r_alu_ctrl;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_to_reg = r_mem_to_reg;
    assign ex_branch     = r_branch;
    assign ex_illegal    = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage. It applies a table of
//                decode vectors, hand sequences for the hazard, flush, freeze
//                and reset cases, and random traffic. Each result is checked
//                against a behavioural model of the EX register.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc, rs1d, rs2d, imm;
        logic [RA_W-1:0] rs1, rs2, rd;
        logic            u1, u2;
        logic [1:0]      op;
        logic [2:0]      f3;
        logic            f7, src, mr, mw, rw, m2r, br;
    } id_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc, a, b, sd;
        logic [RA_W-1:0] rs1, rs2, rd;
        logic [3:0]      ctrl;
        logic            mr, mw, rw, m2r, br, ill;
    } ex_t;

    typedef struct {
        id_t             in;
        logic            rst;
        logic            haz;
        logic            valid;
        logic [3:0]      ctrl;
        logic            ill;
        logic [XLEN-1:0] b;
    } vec_t;

    logic clk = 1'b0;
    logic reset, ext_stall, flush;
    logic id_valid;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
    logic id_uses_rs1, id_uses_rs2;
    logic [1:0] id_alu_op;
    logic [2:0] id_funct3;
    logic id_funct7b5, id_alu_src;
    logic id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch;
    logic hazard_stall;
    logic ex_valid;
    logic [XLEN-1:0] ex_pc, ex_a, ex_b, ex_store_data;
    logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [3:0] ex_alu_ctrl;
    logic ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch, ex_illegal;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk(clk), .reset(reset), .ext_stall(ext_stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2), .id_alu_op(id_alu_op), .id_funct3(id_funct3),
        .id_funct7b5(id_funct7b5), .id_alu_src(id_alu_src),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .id_branch(id_branch), .hazard_stall(hazard_stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b),
        .ex_store_data(ex_store_data), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_alu_ctrl(ex_alu_ctrl), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .ex_illegal(ex_illegal)
    );

    int   checks = 0;
    int   errors = 0;
    ex_t  m;            // model of the EX register
    logic known = 1'b0; // model meaningful only after the first reset

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    function automatic ex_t bubble();
        ex_t e = '0;
        e.ctrl = 4'b0010;
        return e;
    endfunction

    // Decode rules written as a small table of legal combinations.
    function automatic void ref_decode(input logic [1:0] op, input logic [2:0] f3,
                                       input logic f7, output logic [3:0] c,
                                       output logic ill);
        c   = 4'b0010;
        ill = 1'b1;
        if (op == 2'b00) begin c = 4'b0010; ill = 1'b0; end
        else if (op == 2'b01) begin c = 4'b0110; ill = 1'b0; end
        else if (f3 == 3'b111) begin c = 4'b0000; ill = 1'b0; end
        else if (f3 == 3'b110) begin c = 4'b0001; ill = 1'b0; end
        else if (f3 == 3'b000) begin
            c   = (op == 2'b10 && f7) ? 4'b0110 : 4'b0010;
            ill = 1'b0;
        end
    endfunction

    function automatic logic ref_hazard(input id_t x, input logic fl);
        logic dep = (x.u1 && x.rs1 == m.rd) || (x.u2 && x.rs2 == m.rd);
        return x.valid && m.valid && m.mr && (m.rd != 0) && dep && !fl;
    endfunction

    function automatic ex_t ref_load(input id_t x);
        ex_t e;
        e.valid = 1'b1;
        e.pc = x.pc; e.a = x.rs1d; e.sd = x.rs2d;
        e.b  = x.src ? x.imm : x.rs2d;
        e.rs1 = x.rs1; e.rs2 = x.rs2; e.rd = x.rd;
        ref_decode(x.op, x.f3, x.f7, e.ctrl, e.ill);
        e.mr = x.mr; e.mw = x.mw; e.rw = x.rw; e.m2r = x.m2r; e.br = x.br;
        return e;
    endfunction

    function automatic id_t mk(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                               input logic src, input logic [XLEN-1:0] imm,
                               input logic [XLEN-1:0] rs2d);
        id_t x = '0;
        x.valid = 1'b1; x.pc = 32'h100; x.rs1d = 32'hA5A5_0001; x.rs2d = rs2d;
        x.imm = imm; x.rs1 = 5'd2; x.rs2 = 5'd3; x.rd = 5'd1;
        x.op = op; x.f3 = f3; x.f7 = f7; x.src = src; x.rw = 1'b1;
        return x;
    endfunction

    function automatic id_t rand_id();
        id_t x;
        x.valid = ($urandom_range(0, 9) != 0);
        x.pc = $urandom; x.rs1d = $urandom; x.rs2d = $urandom; x.imm = $urandom;
        x.rs1 = RA_W'($urandom_range(0, 3)); x.rs2 = RA_W'($urandom_range(0, 3));
        x.rd = RA_W'($urandom_range(0, 3));
        x.u1 = 1'($urandom); x.u2 = 1'($urandom);
        x.op = 2'($urandom); x.f3 = 3'($urandom); x.f7 = 1'($urandom);
        x.src = 1'($urandom); x.mr = 1'($urandom); x.mw = 1'($urandom);
        x.rw = 1'($urandom); x.m2r = 1'($urandom); x.br = 1'($urandom);
        return x;
    endfunction

    // One clock: drive, check hazard_stall before the edge, advance the
    // model, then check every EX output after the edge.
    task automatic cycle(input id_t x, input logic rst, input logic stl,
                         input logic fl, output logic hz);
        logic hm;
        reset = rst; ext_stall = stl; flush = fl;
        id_valid = x.valid; id_pc = x.pc; id_rs1_data = x.rs1d; id_rs2_data = x.rs2d;
        id_imm = x.imm; id_rs1 = x.rs1; id_rs2 = x.rs2; id_rd = x.rd;
        id_uses_rs1 = x.u1; id_uses_rs2 = x.u2; id_alu_op = x.op; id_funct3 = x.f3;
        id_funct7b5 = x.f7; id_alu_src = x.src; id_mem_read = x.mr;
        id_mem_write = x.mw; id_reg_write = x.rw; id_mem_to_reg = x.m2r; id_branch = x.br;
        #1;
        hz = hazard_stall;
        hm = ref_hazard(x, fl);
        if (known) chk("hazard_stall", 64'(hz), 64'(hm));
        @(posedge clk);
        if (rst) begin m = bubble(); known = 1'b1; end
        else if (stl) m = m;
        else if (fl || hm || !x.valid) m = bubble();
        else m = ref_load(x);
        #1;
        if (known) begin
            chk("ex_valid", 64'(ex_valid), 64'(m.valid));
            chk("ex_pc", 64'(ex_pc), 64'(m.pc));
            chk("ex_a", 64'(ex_a), 64'(m.a));
            chk("ex_b", 64'(ex_b), 64'(m.b));
            chk("ex_store_data", 64'(ex_store_data), 64'(m.sd));
            chk("ex_regs", 64'({ex_rs1, ex_rs2, ex_rd}), 64'({m.rs1, m.rs2, m.rd}));
            chk("ex_alu_ctrl", 64'(ex_alu_ctrl), 64'(m.ctrl));
            chk("ex_ctl_bits",
                64'({ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch, ex_illegal}),
                64'({m.mr, m.mw, m.rw, m.m2r, m.br, m.ill}));
        end
    endtask

    initial begin
        vec_t vt[11];
        id_t  ld, dep, d, x, other;
        logic hz;

        // ---------------- decode table ----------------
        vt[0]  = '{rand_id(), 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 32'h0};
        vt[1]  = '{rand_id(), 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 32'h0};
        vt[2]  = '{mk(2'b10, 3'b000, 1'b1, 1'b0, 32'h0, 32'h1234), 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, 32'h1234};
        vt[3]  = '{mk(2'b11, 3'b110, 1'b0, 1'b1, 32'hFF, 32'h9999), 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 32'hFF};
        vt[4]  = '{mk(2'b10, 3'b010, 1'b0, 1'b0, 32'h7, 32'h55), 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 32'h55};
        vt[5]  = '{mk(2'b00, 3'b101, 1'b1, 1'b1, 32'h10, 32'h0), 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 32'h10};
        vt[6]  = '{mk(2'b01, 3'b001, 1'b0, 1'b0, 32'h0, 32'h66), 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, 32'h66};
        vt[7]  = '{mk(2'b10, 3'b111, 1'b0, 1'b0, 32'h0, 32'h77), 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 32'h77};
        vt[8]  = '{mk(2'b11, 3'b000, 1'b1, 1'b1, 32'h20, 32'h0), 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 32'h20};
        vt[9]  = '{mk(2'b11, 3'b001, 1'b0, 1'b1, 32'h30, 32'h0), 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 32'h30};
        vt[10] = '{mk(2'b10, 3'b000, 1'b0, 1'b0, 32'h0, 32'h88), 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 32'h0};
        vt[10].in.valid = 1'b0;

        for (int i = 0; i < 11; i++) begin
            cycle(vt[i].in, vt[i].rst, 1'b0, 1'b0, hz);
            if (!vt[i].rst) chk("vec_hazard", 64'(hz), 64'(vt[i].haz));
            chk("vec_valid", 64'(ex_valid), 64'(vt[i].valid));
            chk("vec_ctrl", 64'(ex_alu_ctrl), 64'(vt[i].ctrl));
            chk("vec_illegal", 64'(ex_illegal), 64'(vt[i].ill));
            chk("vec_b", 64'(ex_b), 64'(vt[i].b));
        end

        // ---------------- load-use: one bubble ----------------
        ld = mk(2'b00, 3'b010, 1'b0, 1'b1, 32'h4, 32'h0);
        ld.mr = 1'b1; ld.m2r = 1'b1; ld.rd = 5'd5;
        cycle(ld, 1'b0, 1'b0, 1'b0, hz);
        chk("lu_load_in_ex", 64'({ex_mem_read, ex_rd}), 64'({1'b1, 5'd5}));
        dep = mk(2'b10, 3'b000, 1'b0, 1'b0, 32'h0, 32'hAB);
        dep.rs2 = 5'd5; dep.u2 = 1'b1;
        cycle(dep, 1'b0, 1'b0, 1'b0, hz);
        chk("lu_stall", 64'(hz), 64'd1);
        chk("lu_bubble", 64'(ex_valid), 64'd0);
        cycle(dep, 1'b0, 1'b0, 1'b0, hz);
        chk("lu_release", 64'(hz), 64'd0);
        chk("lu_loaded", 64'({ex_valid, ex_rs2}), 64'({1'b1, 5'd5}));

        // ---------------- rd = x0 / unused operand ----------------
        ld.rd = 5'd0;
        cycle(ld, 1'b0, 1'b0, 1'b0, hz);
        d = dep; d.rs1 = 5'd0; d.u1 = 1'b1; d.rs2 = 5'd3; d.u2 = 1'b0;
        cycle(d, 1'b0, 1'b0, 1'b0, hz);
        chk("x0_no_stall", 64'({hz, ex_valid}), 64'({1'b0, 1'b1}));
        ld.rd = 5'd7;
        cycle(ld, 1'b0, 1'b0, 1'b0, hz);
        d = dep; d.rs2 = 5'd7; d.u2 = 1'b0; d.rs1 = 5'd3; d.u1 = 1'b1;
        cycle(d, 1'b0, 1'b0, 1'b0, hz);
        chk("unused_no_stall", 64'({hz, ex_valid}), 64'({1'b0, 1'b1}));

        // ---------------- flush beats hazard ----------------
        ld.rd = 5'd9;
        cycle(ld, 1'b0, 1'b0, 1'b0, hz);
        d = dep; d.rs1 = 5'd9; d.u1 = 1'b1;
        cycle(d, 1'b0, 1'b0, 1'b1, hz);
        chk("flush_haz_stall", 64'(hz), 64'd0);
        chk("flush_bubble", 64'(ex_valid), 64'd0);

        // ---------------- ext_stall beats flush ----------------
        x = mk(2'b11, 3'b111, 1'b0, 1'b1, 32'h5, 32'h0); x.pc = 32'h400;
        other = mk(2'b10, 3'b110, 1'b0, 1'b0, 32'h0, 32'h3); other.pc = 32'h800;
        cycle(x, 1'b0, 1'b0, 1'b0, hz);
        cycle(other, 1'b0, 1'b1, 1'b1, hz);
        chk("stall_flush_hold", 64'({ex_valid, ex_pc}), 64'({1'b1, 32'h400}));
        cycle(other, 1'b0, 1'b1, 1'b1, hz);
        chk("stall_hold_2", 64'({ex_alu_ctrl, ex_pc}), 64'({4'b0000, 32'h400}));
        cycle(other, 1'b0, 1'b0, 1'b1, hz);
        chk("unstall_flush", 64'({ex_valid, ex_pc}), 64'({1'b0, 32'h0}));

        // ---------------- reset during freeze ----------------
        cycle(x, 1'b0, 1'b0, 1'b0, hz);
        cycle(other, 1'b0, 1'b1, 1'b0, hz);
        cycle(other, 1'b1, 1'b1, 1'b0, hz);
        chk("mid_reset", 64'({ex_valid, ex_alu_ctrl, ex_pc}), 64'({1'b0, 4'b0010, 32'h0}));
        cycle(other, 1'b0, 1'b0, 1'b0, hz);
        chk("post_reset_load", 64'({ex_valid, ex_alu_ctrl, ex_pc}), 64'({1'b1, 4'b0001, 32'h800}));

        // ---------------- random traffic ----------------
        for (int i = 0; i < 600; i++) begin
            cycle(rand_id(), ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) == 0), hz);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
